// File: rtl/dcache_sa_ctrl.sv
// Set-associative write-back / write-allocate data cache between the CPU MEM stage and a 256-bit memory.
// Hits answer combinationally; misses stall through WB -> ALLOC -> RETRY; flush walks every line in set/way order.
module dcache_sa_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 256,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB      = 3'd1;
  localparam logic [2:0] S_ALLOC   = 3'd2;
  localparam logic [2:0] S_RETRY   = 3'd3;
  localparam logic [2:0] S_FL_SCAN = 3'd4;
  localparam logic [2:0] S_FL_WB   = 3'd5;

  logic [2:0]          r_state;
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0] r_mru;
  logic [1:0]          r_rr    [NUM_SETS];

  logic [WAY_W-1:0]    r_vic_way;
  logic [TAG_W-1:0]    r_vic_tag;
  logic [TAG_W-1:0]    r_req_tag;
  logic [IDX_W-1:0]    r_idx;
  logic                r_refill;
  logic                r_flush_pend;
  logic                r_flush_done;
  logic [IDX_W-1:0]    r_fl_set;
  logic [WAY_W-1:0]    r_fl_way;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic                w_req;
  logic                w_wr;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WSEL_W-1:0]   w_wsel;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic                w_idle_hit;
  logic [LINE_W-1:0]   w_hit_line;
  logic [DATA_W-1:0]   w_hit_word;
  logic                w_inv_found;
  logic [WAY_W-1:0]    w_vic;
  logic                w_vic_dirty;
  logic                w_fl_way_last;
  logic                w_fl_last;
  logic                w_fl_dirty;
  logic                w_unused_ok;

  assign w_req       = p1_MemRead_i | p1_MemWrite_i;
  assign w_wr        = p1_MemWrite_i;
  assign w_tag       = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx       = p1_addr_i[OFF_W +: IDX_W];
  assign w_wsel      = p1_addr_i[2 +: WSEL_W];
  assign w_unused_ok = ^p1_addr_i[1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_idle_hit = (r_state == S_IDLE) && w_req && w_hit;
  assign w_hit_line = r_data[w_idx][w_hit_way];
  assign w_hit_word = w_hit_line[w_wsel*DATA_W +: DATA_W];

  // Downward scan so the lowest-index invalid way is the one left standing.
  always_comb begin
    w_inv_found = 1'b0;
    w_vic       = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_vic       = WAY_W'(w);
      end
    end
    if (!w_inv_found) begin
      if (NUM_WAYS == 1)      w_vic = '0;
      else if (NUM_WAYS == 2) w_vic = WAY_W'(!r_mru[w_idx]);
      else                    w_vic = WAY_W'(r_rr[w_idx]);
    end
  end

  assign w_vic_dirty   = r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic];
  assign w_fl_way_last = (r_fl_way == WAY_W'(NUM_WAYS - 1));
  assign w_fl_last     = w_fl_way_last && (r_fl_set == IDX_W'(NUM_SETS - 1));
  assign w_fl_dirty    = r_valid[r_fl_set][r_fl_way] && r_dirty[r_fl_set][r_fl_way];

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (r_state)
      S_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_vic_tag, r_idx, {OFF_W{1'b0}}};
        mem_data_o   = r_data[r_idx][r_vic_way];
      end
      S_ALLOC: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_req_tag, r_idx, {OFF_W{1'b0}}};
      end
      S_FL_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[r_fl_set][r_fl_way], r_fl_set, {OFF_W{1'b0}}};
        mem_data_o   = r_data[r_fl_set][r_fl_way];
      end
      default: ;
    endcase
  end

  assign p1_stall_o   = rst_i & w_req & ((r_state != S_IDLE) | ~w_hit);
  assign p1_data_o    = w_idle_hit ? w_hit_word : '0;
  assign flush_busy_o = (r_state == S_FL_SCAN) || (r_state == S_FL_WB);
  assign flush_done_o = r_flush_done;
  assign hit_cnt_o    = r_hit_cnt;
  assign miss_cnt_o   = r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_mru        <= '0;
      r_vic_way    <= '0;
      r_vic_tag    <= '0;
      r_req_tag    <= '0;
      r_idx        <= '0;
      r_refill     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_flush_done <= 1'b0;
      r_fl_set     <= '0;
      r_fl_way     <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (w_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
              r_mru[w_idx] <= w_hit_way[0];
              if (!r_refill) r_hit_cnt <= r_hit_cnt + 32'd1;
              r_refill <= 1'b0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 32'd1;
              r_vic_way  <= w_vic;
              r_vic_tag  <= r_tag[w_idx][w_vic];
              r_req_tag  <= w_tag;
              r_idx      <= w_idx;
              r_state    <= w_vic_dirty ? S_WB : S_ALLOC;
            end
          end else if (r_flush_pend) begin
            r_flush_pend <= 1'b0;
            r_fl_set     <= '0;
            r_fl_way     <= '0;
            r_state      <= S_FL_SCAN;
          end
        end
        S_WB: begin
          if (mem_ack_i) r_state <= S_ALLOC;
        end
        S_ALLOC: begin
          if (mem_ack_i) begin
            r_valid[r_idx][r_vic_way] <= 1'b1;
            r_dirty[r_idx][r_vic_way] <= 1'b0;
            r_rr[r_idx]               <= r_rr[r_idx] + 2'd1;
            r_refill                  <= 1'b1;
            r_state                   <= S_RETRY;
          end
        end
        S_RETRY: r_state <= S_IDLE;
        S_FL_SCAN, S_FL_WB: begin
          // A scan of a clean line and an acked write-back both retire the cursor position.
          if ((r_state == S_FL_SCAN) && w_fl_dirty) begin
            r_state <= S_FL_WB;
          end else if ((r_state == S_FL_SCAN) || mem_ack_i) begin
            if (r_state == S_FL_WB) r_dirty[r_fl_set][r_fl_way] <= 1'b0;
            if (w_fl_last) begin
              r_flush_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_FL_SCAN;
              if (w_fl_way_last) begin
                r_fl_way <= '0;
                r_fl_set <= r_fl_set + IDX_W'(1);
              end else begin
                r_fl_way <= r_fl_way + WAY_W'(1);
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (flush_i) r_flush_pend <= 1'b1;
    end
  end

  // Tag and line storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (w_idle_hit && w_wr)
        r_data[w_idx][w_hit_way][w_wsel*DATA_W +: DATA_W] <= p1_data_i;
      if ((r_state == S_ALLOC) && mem_ack_i) begin
        r_data[r_idx][r_vic_way] <= mem_data_i;
        r_tag[r_idx][r_vic_way]  <= r_req_tag;
      end
    end
  end

endmodule

// File: doc/dcache_sa_ctrl.md
Name: dcache_sa_ctrl

Overview:
- Parametrised set-associative, write-back, write-allocate data cache. Successor to the current direct-mapped dcache_top.
- Sits between the CPU EX/MEM stage (p1_* interface) and the 256-bit off-chip data memory (mem_* interface).
- Adds configurable sets and ways, replacement policy, an explicit dirty-line flush walk, and hit/miss statistics.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, CPU word width
LINE_W, 256, cache line / memory beat width (OFF_W = log2(LINE_W/8) = 5)
NUM_SETS, 16, sets, power of two (IDX_W = log2(NUM_SETS))
NUM_WAYS, 2, associativity; legal values 1, 2, 4 (TAG_W = ADDR_W-IDX_W-OFF_W)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
p1_addr_i  in  ADDR_W  CPU byte address
p1_data_i  in  DATA_W  CPU store data
p1_MemRead_i  in  1  load request (level)
p1_MemWrite_i  in  1  store request (level)
p1_data_o  out  DATA_W  load data
p1_stall_o  out  1  freeze CPU pipeline
flush_i  in  1  request write-back of all dirty lines (pulse)
flush_busy_o  out  1  flush walk in progress
flush_done_o  out  1  one-cycle pulse at end of flush
mem_data_i  in  LINE_W  refill line
mem_ack_i  in  1  one-cycle completion pulse
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits zero)
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill
hit_cnt_o  out  32  lookup hits, wraps at 2^32
miss_cnt_o  out  32  lookup misses, wraps at 2^32

Behaviour:
- Address split: tag = [ADDR_W-1 : IDX_W+OFF_W], index = [IDX_W+OFF_W-1 : OFF_W], word = [OFF_W-1 : 2]. Bits [1:0] are ignored; only aligned word access is supported.
- Request = MemRead | MemWrite. Both asserted together is treated as a write.
- Per line: valid, dirty, tag, LINE_W data. Per set: MRU bit (2-way) or 2-bit round-robin pointer (4-way).
- Reset (rst_i=0, asynchronous):
  - state -> IDLE.
  - All valid, dirty, MRU and pointer bits -> 0.
  - Counters -> 0; flush_pend -> 0.
  - All outputs 0.
  - Reset mid-transaction drops mem_enable_o immediately. Dirty data is lost by design.
- States:
  - IDLE
  - WB: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line.
  - ALLOC: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 0}.
  - RETRY
  - FL_SCAN
  - FL_WB
- IDLE hit (request, valid and tag match in some way):
  - p1_stall_o=0 combinationally in the same cycle; p1_data_o = selected word.
  - On the clock edge: a write updates the word and sets dirty; MRU/replacement info is updated; hit_cnt increments unless refill_flag is set. refill_flag is then cleared.
- IDLE miss:
  - p1_stall_o=1 in the same cycle; miss_cnt increments.
  - Victim is latched, then go to WB if victim is valid and dirty, else to ALLOC.
- Victim selection:
  - First choice: lowest-index invalid way.
  - Else 1-way: way 0. 2-way: the non-MRU way. 4-way: the round-robin pointer, which advances on each refill.
- WB -> ALLOC on mem_ack_i.
- ALLOC -> RETRY on mem_ack_i. On that edge the victim way gets: line = mem_data_i, tag, valid=1, dirty=0; refill_flag is set.
- RETRY: stall=1 for one cycle, then IDLE. The retried access hits, and is not counted as a hit.
- mem_enable_o is held high until mem_ack_i. mem_addr_o, mem_data_o and mem_write_o are stable while enable is high. mem_ack_i is ignored in IDLE, FL_SCAN and RETRY.
- p1_stall_o = request & (state != IDLE or IDLE miss). p1_data_o = 0 when no hit.
- Flush:
  - flush_i sets flush_pend. In IDLE with no request and flush_pend, clear it and go to FL_SCAN with cursor (set 0, way 0); flush_busy_o=1.
  - FL_SCAN: one cycle per line. If the line is valid and dirty go to FL_WB, else advance the cursor (way first, then set).
  - FL_WB: write-back handshake as in WB. On ack, clear dirty (valid kept), advance the cursor, return to FL_SCAN.
  - After the last line: flush_done_o pulses one cycle, then IDLE.
  - Requests arriving during the flush are stalled. Flush does not change the counters.
  - flush_i during a flush re-sets flush_pend, so a second walk follows.

Test Plan:
- Reset, then read 0x00000404 -> stall=1, ALLOC with mem_addr_o=0x00000400 and mem_write_o=0. Memory acks after 10 cycles with a line whose word1 = 0x11111111. Then RETRY; stall drops; p1_data_o=0x11111111; miss_cnt=1, hit_cnt=0.
- Write 0xDEADBEEF to 0x00000404, then read 0x00000404 -> both accesses have stall=0 in the same cycle; read returns 0xDEADBEEF; hit_cnt=2; no mem_enable_o.
- 2-way, set 0 conflict:
  - Write 0x400, read 0x600, read 0x400, read 0x800 -> the 0x600 way is evicted with no WB.
  - Then read 0xA00 -> WB to 0x400 (mem_write_o=1, mem_data_o carries the 0xDEADBEEF word), then ALLOC of 0xA00; miss_cnt=4.
- Dirty lines in sets 0 and 3, pulse flush_i -> two WBs, addresses in ascending set order, then one flush_done_o pulse. A second flush produces zero WBs. Later reads of those addresses hit.
- Drive rst_i low while mem_enable_o=1 in ALLOC -> mem_enable_o and p1_stall_o go to 0 immediately and counters clear; the first read after reset misses.
- mem_ack_i pulses while in IDLE -> no state change and no array write.
